// File: rtl/crc_process.sv
// Receive-side frame gate: buffers each MAC RX frame until its CRC verdict
// arrives, then forwards good frames unchanged and silently drops bad ones.
module crc_process #(
  parameter int P_DATA_DEPTH    = 512,
  parameter int P_MAX_BEATS     = 192,
  parameter int P_VERDICT_DEPTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] s_axis_rdata,
  input  logic [79:0] s_axis_ruser,
  input  logic [7:0]  s_axis_rkeep,
  input  logic        s_axis_rlast,
  input  logic        s_axis_rvalid,
  input  logic        i_crc_error,
  input  logic        i_crc_valid,
  output logic [63:0] m_axis_rdata,
  output logic [79:0] m_axis_ruser,
  output logic [7:0]  m_axis_rkeep,
  output logic        m_axis_rlast,
  output logic        m_axis_rvalid,
  output logic [1:0]  dbg_state
);
  // Handshake: both streams are valid-only. A beat (or verdict) transfers on
  // every cycle its valid is high; there is no ready and no backpressure.

  localparam int AW = $clog2(P_DATA_DEPTH);
  localparam int VW = $clog2(P_VERDICT_DEPTH);
  localparam int BW = 153;
  localparam logic [AW:0] ADMIT_LIMIT = (AW+1)'(P_DATA_DEPTH - P_MAX_BEATS);
  localparam logic [VW:0] Q_FULL      = (VW+1)'(P_VERDICT_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, DISCARD = 2'd2} state_t;
  state_t state;

  logic [BW-1:0] data_mem [P_DATA_DEPTH];
  logic          info_mem [P_VERDICT_DEPTH];
  logic          verd_mem [P_VERDICT_DEPTH];

  logic [AW:0] wr_ptr, rd_ptr, data_cnt;
  logic [VW:0] info_wr, info_rd, info_cnt;
  logic [VW:0] verd_wr, verd_rd, verd_cnt;

  logic          in_frame, admit_q;
  logic          first_beat, admit_now, cur_admit;
  logic          data_we, info_we, verd_we, pop, rd_last;
  logic          info_full, verd_full;
  logic          rd_v;
  logic [BW-1:0] rd_q;

  assign data_cnt  = wr_ptr - rd_ptr;
  assign info_cnt  = info_wr - info_rd;
  assign verd_cnt  = verd_wr - verd_rd;
  assign info_full = (info_cnt == Q_FULL);
  assign verd_full = (verd_cnt == Q_FULL);

  // Admission is decided once per frame on its first beat and held until rlast.
  assign first_beat = s_axis_rvalid && !in_frame;
  assign admit_now  = (data_cnt <= ADMIT_LIMIT) && !info_full;
  assign cur_admit  = first_beat ? admit_now : admit_q;
  assign data_we    = s_axis_rvalid && cur_admit;

  assign pop     = (state == IDLE) && (info_cnt != '0) && (verd_cnt != '0);
  assign info_we = s_axis_rvalid && s_axis_rlast && (!info_full || pop);
  assign verd_we = i_crc_valid && (!verd_full || pop);
  assign rd_last = data_mem[rd_ptr[AW-1:0]][0];

  assign dbg_state = state;

  always_ff @(posedge i_clk) begin
    if (data_we)
      data_mem[wr_ptr[AW-1:0]] <= {s_axis_rdata, s_axis_ruser, s_axis_rkeep, s_axis_rlast};
    if (info_we)
      info_mem[info_wr[VW-1:0]] <= !cur_admit;
    if (verd_we)
      verd_mem[verd_wr[VW-1:0]] <= i_crc_error;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      info_wr       <= '0;
      info_rd       <= '0;
      verd_wr       <= '0;
      verd_rd       <= '0;
      in_frame      <= 1'b0;
      admit_q       <= 1'b0;
      rd_v          <= 1'b0;
      rd_q          <= '0;
      m_axis_rdata  <= '0;
      m_axis_ruser  <= '0;
      m_axis_rkeep  <= '0;
      m_axis_rlast  <= 1'b0;
      m_axis_rvalid <= 1'b0;
    end else begin
      if (s_axis_rvalid) begin
        in_frame <= !s_axis_rlast;
        admit_q  <= cur_admit;
      end
      if (data_we) wr_ptr  <= wr_ptr + 1'b1;
      if (info_we) info_wr <= info_wr + 1'b1;
      if (verd_we) verd_wr <= verd_wr + 1'b1;
      if (pop) begin
        info_rd <= info_rd + 1'b1;
        verd_rd <= verd_rd + 1'b1;
      end

      // Two-stage read path: buffer read register, then the output register.
      rd_v <= (state == FWD);
      rd_q <= data_mem[rd_ptr[AW-1:0]];
      m_axis_rvalid <= rd_v;
      m_axis_rdata  <= rd_v ? rd_q[152:89] : '0;
      m_axis_ruser  <= rd_v ? rd_q[88:9]   : '0;
      m_axis_rkeep  <= rd_v ? rd_q[8:1]    : '0;
      m_axis_rlast  <= rd_v ? rd_q[0]      : 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            if (info_mem[info_rd[VW-1:0]])
              state <= IDLE;
            else if (verd_mem[verd_rd[VW-1:0]])
              state <= DISCARD;
            else
              state <= FWD;
          end
        end
        FWD, DISCARD: begin
          rd_ptr <= rd_ptr + 1'b1;
          if (rd_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_process.sv
// Randomized and directed bench for crc_process with a scoreboard queue of
// expected output beats fed by the driver and drained by a negedge monitor.
module tb_crc_process;
  localparam int W = 153;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [63:0] s_axis_rdata;
  logic [79:0] s_axis_ruser;
  logic [7:0]  s_axis_rkeep;
  logic        s_axis_rlast;
  logic        s_axis_rvalid;
  logic        i_crc_error;
  logic        i_crc_valid;
  logic [63:0] m_axis_rdata;
  logic [79:0] m_axis_ruser;
  logic [7:0]  m_axis_rkeep;
  logic        m_axis_rlast;
  logic        m_axis_rvalid;
  logic [1:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  bit prev_v = 0;
  bit prev_last = 0;

  crc_process #(
    .P_DATA_DEPTH(16), .P_MAX_BEATS(8), .P_VERDICT_DEPTH(16)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .s_axis_rdata(s_axis_rdata), .s_axis_ruser(s_axis_ruser),
    .s_axis_rkeep(s_axis_rkeep), .s_axis_rlast(s_axis_rlast),
    .s_axis_rvalid(s_axis_rvalid),
    .i_crc_error(i_crc_error), .i_crc_valid(i_crc_valid),
    .m_axis_rdata(m_axis_rdata), .m_axis_ruser(m_axis_ruser),
    .m_axis_rkeep(m_axis_rkeep), .m_axis_rlast(m_axis_rlast),
    .m_axis_rvalid(m_axis_rvalid), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    repeat (60000) @(posedge i_clk);
    n_err++;
    $display("FAIL watchdog: run did not complete, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_v    = 0;
      prev_last = 0;
    end else begin
      if (m_axis_rvalid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got data %h user %h, required no beat",
                   m_axis_rdata, m_axis_ruser);
        end else begin
          logic [W-1:0] e;
          logic [W-1:0] g;
          e = exp_q.pop_front();
          g = {m_axis_rdata, m_axis_ruser, m_axis_rkeep, m_axis_rlast};
          if (g !== e) begin
            n_err++;
            $display("FAIL beat: got %h required %h", g, e);
          end
        end
      end else begin
        n_cmp++;
        if ({m_axis_rdata, m_axis_ruser, m_axis_rkeep, m_axis_rlast} !== '0) begin
          n_err++;
          $display("FAIL idle_zero: got fields %h %h %h %b while rvalid=0, required 0",
                   m_axis_rdata, m_axis_ruser, m_axis_rkeep, m_axis_rlast);
        end
      end
      if (prev_v && !prev_last) begin
        n_cmp++;
        if (!m_axis_rvalid) begin
          n_err++;
          $display("FAIL contiguous: got rvalid 0 inside frame, required 1");
        end
      end
      if (prev_v && prev_last) begin
        n_cmp++;
        if (m_axis_rvalid) begin
          n_err++;
          $display("FAIL frame_gap: got rvalid 1 right after rlast, required 0");
        end
      end
      prev_v    = m_axis_rvalid;
      prev_last = m_axis_rlast;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic idle_inputs();
    s_axis_rdata  = '0;
    s_axis_ruser  = '0;
    s_axis_rkeep  = '0;
    s_axis_rlast  = 1'b0;
    s_axis_rvalid = 1'b0;
    i_crc_error   = 1'b0;
    i_crc_valid   = 1'b0;
  endtask

  // Sends a len-beat frame; the verdict strobe fires voff cycles after the
  // first beat (voff < 0: no verdict). fwd says whether the model expects it out.
  task automatic send_frame(input int len, input bit err, input int voff,
                            input logic [79:0] user, input logic [7:0] keep_last,
                            input bit fwd);
    logic [63:0] data [];
    int ncyc;
    data = new[len];
    for (int i = 0; i < len; i++) begin
      data[i] = {$urandom, $urandom};
      if (fwd)
        exp_q.push_back({data[i], user, (i == len-1) ? keep_last : 8'hFF, i == len-1});
    end
    ncyc = (voff + 1 > len) ? voff + 1 : len;
    for (int c = 0; c < ncyc; c++) begin
      idle_inputs();
      if (c < len) begin
        s_axis_rvalid = 1'b1;
        s_axis_rdata  = data[c];
        s_axis_ruser  = user;
        s_axis_rlast  = (c == len-1);
        s_axis_rkeep  = (c == len-1) ? keep_last : 8'hFF;
      end
      if (c == voff) begin
        i_crc_valid = 1'b1;
        i_crc_error = err;
      end
      @(posedge i_clk); #1;
    end
    idle_inputs();
  endtask

  task automatic send_verdict(input bit err);
    i_crc_valid = 1'b1;
    i_crc_error = err;
    @(posedge i_clk); #1;
    idle_inputs();
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge i_clk); #1;
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_%s: got %0d beats still pending, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    repeat (12) @(posedge i_clk);
    #1;
  endtask

  function automatic logic [79:0] rand_user(input int len);
    return {16'(len * 8), 32'($urandom), 16'($urandom), 16'($urandom)};
  endfunction

  function automatic logic [7:0] rand_keep();
    logic [7:0] k;
    k = 8'hFF;
    k = k << (8 - $urandom_range(1, 8));
    return k;
  endfunction

  // ---------------- stimulus ----------------
  localparam logic [79:0] USER_A = {16'd10, 48'h0102_0304_0506, 16'h0800};

  initial begin
    int lat;
    bit seq_err [6];
    idle_inputs();
    i_rst = 1'b1;
    repeat (4) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(posedge i_clk); #1;

    check("reset_rvalid", W'(m_axis_rvalid), W'(0));
    check("reset_fields", {m_axis_rdata, m_axis_ruser, m_axis_rkeep, m_axis_rlast}, '0);

    // Good frame with verdict three cycles after rlast; first beat latency.
    send_frame(5, 1'b0, 7, USER_A, 8'b1000_0000, 1'b1);
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge i_clk); #1;
      if (m_axis_rvalid) begin
        lat = n;
        break;
      end
    end
    check("first_beat_latency", W'(lat), W'(3));
    wait_drain("good");

    // Bad frame is discarded; a following good frame comes through intact.
    send_frame(5, 1'b1, 7, USER_A, 8'b1000_0000, 1'b0);
    wait_drain("bad");
    send_frame(5, 1'b0, 7, USER_A, 8'b1000_0000, 1'b1);
    wait_drain("after_bad");

    // Six-frame verdict sequence: good, err, good, err, err, good.
    seq_err = '{0, 1, 0, 1, 1, 0};
    for (int f = 0; f < 6; f++) begin
      int len = $urandom_range(3, 8);
      send_frame(len, seq_err[f], len + 1, rand_user(len), rand_keep(), !seq_err[f]);
      wait_drain("seq6");
    end

    // Early verdicts: on the rlast cycle, then on the first beat.
    send_frame(6, 1'b0, 5, rand_user(6), rand_keep(), 1'b1);
    wait_drain("early_last");
    send_frame(6, 1'b0, 0, rand_user(6), rand_keep(), 1'b1);
    wait_drain("early_first");
    send_frame(1, 1'b0, 0, rand_user(1), rand_keep(), 1'b1);
    wait_drain("single_beat");

    // Admission: 16-entry buffer, 8-beat frames back to back, verdicts late.
    send_frame(8, 1'b0, -1, rand_user(8), 8'hFF, 1'b1);
    send_frame(8, 1'b0, -1, rand_user(8), 8'hC0, 1'b1);
    send_frame(8, 1'b0, -1, rand_user(8), 8'hF0, 1'b0);
    send_verdict(1'b0);
    send_verdict(1'b0);
    send_verdict(1'b1);
    wait_drain("admit12");
    send_frame(4, 1'b0, 5, rand_user(4), rand_keep(), 1'b1);
    wait_drain("admit_next");

    // Reset during output beat 2 flushes everything.
    send_frame(5, 1'b0, 6, USER_A, 8'b1000_0000, 1'b1);
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge i_clk); #1;
      if (m_axis_rvalid) begin
        lat = n;
        break;
      end
    end
    check("reset_test_start", W'(lat != 0), W'(1));
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check("midreset_rvalid", W'(m_axis_rvalid), W'(0));
    check("midreset_fields", {m_axis_rdata, m_axis_ruser, m_axis_rkeep, m_axis_rlast}, '0);
    i_rst = 1'b0;
    exp_q.delete();
    @(posedge i_clk); #1;
    send_frame(5, 1'b0, 6, USER_A, 8'b1000_0000, 1'b1);
    wait_drain("after_reset");

    // Randomized frames, lengths, keeps, verdicts and verdict timing.
    for (int f = 0; f < 30; f++) begin
      int len = $urandom_range(1, 8);
      bit err = 1'($urandom_range(0, 1));
      int voff = $urandom_range(0, len + 4);
      send_frame(len, err, voff, rand_user(len), rand_keep(), !err);
      wait_drain("random");
    end

    check("final_queue_empty", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
